keycode_event_queue: RTL

- Consumes the 8-bit keycode held in the Nios II keycode PIO output register and turns level changes into discrete key events: PRESS, REPEAT (typematic) and RELEASE.
- Events are queued in a small show-ahead FIFO that the downstream text-mode logic drains with a valid/ready handshake.
- Sits directly downstream of the keycode PIO in the same clock domain. Keycode 0x00 means "no key".

---
 rtl/keycode_event_queue_if.sv | 39 +++
 rtl/keycode_event_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/keycode_event_queue_if.sv
`default_nettype none
// =============================================================================
// Module  : keycode_event_queue_if
// Desc    : Event-stream handshake plus queue status between the keycode event
//           queue (master) and its consumer (slave).
// Rev     : 1.0
// =============================================================================
interface keycode_event_queue_if #(
    parameter int FIFO_DEPTH = 8
) ();
    logic                        evt_valid;
    logic                        evt_ready;
    logic [7:0]                  evt_code;
    logic [1:0]                  evt_type;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        overflow;
    logic                        overflow_clr;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_type,
        output fifo_level,
        output overflow,
        input  evt_ready,
        input  overflow_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_type,
        input  fifo_level,
        input  overflow,
        output evt_ready,
        output overflow_clr
    );
endinterface
`default_nettype wire

// File: rtl/keycode_event_queue.sv
`default_nettype none
// =============================================================================
// Module  : keycode_event_queue
// Desc    : Turns PIO keycode level changes into PRESS/REPEAT/RELEASE events
//           held in a show-ahead FIFO. Define KEYEVT_TYPEMATIC_EN to enable
//           typematic REPEAT generation; otherwise only PRESS/RELEASE occur.
// Rev     : 1.0
// =============================================================================
module keycode_event_queue #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int FIFO_DEPTH    = 8
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic [7:0]      keycode_in,
    keycode_event_queue_if.master evt_if
);
    localparam int         c_AW          = $clog2(FIFO_DEPTH);
    localparam int         c_LW          = c_AW + 1;
    localparam logic [c_AW:0] c_FULL     = c_LW'(FIFO_DEPTH);
    localparam logic [1:0] c_EVT_PRESS   = 2'b01;
    localparam logic [1:0] c_EVT_RELEASE = 2'b11;

    generate
        if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("keycode_event_queue: illegal parameter set");
        end
    endgenerate

`ifdef KEYEVT_TYPEMATIC_EN
    localparam logic [1:0]     c_EVT_REPEAT = 2'b10;
    localparam int             c_CNT_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             c_CW         = $clog2(c_CNT_MAX);
    localparam logic [c_CW-1:0] c_DLY_LAST  = c_CW'(REPEAT_DELAY - 1);
    localparam logic [c_CW-1:0] c_PER_LAST  = c_CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RPT   = 2'd2,
        S_ROLL  = 2'd3
    } state_t;

    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [c_CW-1:0] w_cnt_last;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_ROLL = 2'd2
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] kc_q;
    logic [7:0] held_q, held_d;
    logic       w_push;
    logic [1:0] w_push_type;
    logic [7:0] w_push_code;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            kc_q    <= 8'h00;
            held_q  <= 8'h00;
`ifdef KEYEVT_TYPEMATIC_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            kc_q    <= keycode_in;
            held_q  <= held_d;
`ifdef KEYEVT_TYPEMATIC_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        w_push      = 1'b0;
        w_push_type = 2'b00;
        w_push_code = 8'h00;
`ifdef KEYEVT_TYPEMATIC_EN
        cnt_d       = cnt_q;
        w_cnt_last  = (state_q == S_DELAY) ? c_DLY_LAST : c_PER_LAST;
`endif
        case (state_q)
            // ROLL differs from IDLE only in clearing the stale held key.
            S_IDLE, S_ROLL: begin
                if (kc_q != 8'h00) begin
                    w_push      = 1'b1;
                    w_push_type = c_EVT_PRESS;
                    w_push_code = kc_q;
                    held_d      = kc_q;
`ifdef KEYEVT_TYPEMATIC_EN
                    cnt_d       = '0;
                    state_d     = S_DELAY;
`else
                    state_d     = S_HELD;
`endif
                end else if (state_q == S_ROLL) begin
                    held_d  = 8'h00;
                    state_d = S_IDLE;
                end
            end
`ifdef KEYEVT_TYPEMATIC_EN
            S_DELAY, S_RPT: begin
`else
            S_HELD: begin
`endif
                if (kc_q == 8'h00) begin
                    w_push      = 1'b1;
                    w_push_type = c_EVT_RELEASE;
                    w_push_code = held_q;
                    held_d      = 8'h00;
                    state_d     = S_IDLE;
`ifdef KEYEVT_TYPEMATIC_EN
                    cnt_d       = '0;
`endif
                end else if (kc_q != held_q) begin
                    w_push      = 1'b1;
                    w_push_type = c_EVT_RELEASE;
                    w_push_code = held_q;
                    state_d     = S_ROLL;
`ifdef KEYEVT_TYPEMATIC_EN
                    cnt_d       = '0;
                end else if (cnt_q == w_cnt_last) begin
                    w_push      = 1'b1;
                    w_push_type = c_EVT_REPEAT;
                    w_push_code = held_q;
                    cnt_d       = '0;
                    state_d     = S_RPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [c_AW:0] wr_q, rd_q;
    logic [c_AW:0] w_wr_next, w_rd_next, w_level;
    logic [9:0]  head_q, head_d;
    logic        ovf_q, ovf_d;
    logic        w_empty, w_full, w_pop, w_do_push, w_drop;

    assign w_level   = wr_q - rd_q;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == c_FULL);
    assign w_pop     = evt_if.evt_ready && !w_empty;
    assign w_do_push = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_wr_next = wr_q + {{c_AW{1'b0}}, w_do_push};
    assign w_rd_next = rd_q + {{c_AW{1'b0}}, w_pop};

    // Head is registered so it can hold its last value once the queue drains;
    // a push into an empty (or emptying) queue bypasses the array.
    always_comb begin
        head_d = head_q;
        if (w_wr_next != w_rd_next) begin
            if (w_rd_next == wr_q) begin
                head_d = {w_push_type, w_push_code};
            end else begin
                head_d = mem_q[w_rd_next[c_AW-1:0]];
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (evt_if.overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_q[c_AW-1:0]] <= {w_push_type, w_push_code};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= w_wr_next;
            rd_q   <= w_rd_next;
            head_q <= head_d;
            ovf_q  <= ovf_d;
        end
    end

    assign evt_if.evt_valid  = !w_empty;
    assign evt_if.evt_code   = head_q[7:0];
    assign evt_if.evt_type   = head_q[9:8];
    assign evt_if.fifo_level = w_level;
    assign evt_if.overflow   = ovf_q;
endmodule
`default_nettype wire
